// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial adder/subtractor.
// Processes W bits per cycle from the LSB digit upward and takes K = N/W cycles,
// then raises carry/zero/overflow/negative flags.
module addsub_seq #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         c_flag,
    output logic         z_flag,
    output logic         v_flag,
    output logic         n_flag
);

    localparam int K  = N / W;
    localparam int CW = $clog2(K) + 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (!(W >= 1 && W <= N && (N % W) == 0)) begin : g_bad_param
        $error("addsub_seq: W must divide N and satisfy 1 <= W <= N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_carry;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [N-1:0]  r_y;
    logic          r_c;
    logic          r_z;
    logic          r_v;
    logic          r_n;

    logic          w_accept;
    logic          w_last;
    logic [W:0]    w_sum;
    logic [N-1:0]  w_y_next;
    logic [N-1:0]  w_b_eff;
    logic          w_cin;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == LAST);

    // Subtract ops fold the inversion into the latched operand; op[0] selects subtract
    assign w_b_eff = op[0] ? ~b : b;
    // ADC/SBC chain through the registered carry; ADD/SUB use 0/1
    assign w_cin   = op[1] ? r_c : op[0];

    // One digit per RUN cycle: the operand shift registers always present the current digit at bit 0
    assign w_sum = {1'b0, r_a[W-1:0]} + {1'b0, r_b[W-1:0]} + {{W{1'b0}}, r_carry};

    // Result digits enter at the top of y and shift down, so after K cycles digit 0 sits at the LSB
    if (W == N) begin : g_single
        assign w_y_next = w_sum[W-1:0];
    end else begin : g_multi
        assign w_y_next = {w_sum[W-1:0], r_y[N-1:W]};
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign v_flag    = r_v;
    assign n_flag    = r_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch, digit datapath, result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_y     <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin;
            r_a_msb <= a[N-1];
            r_b_msb <= w_b_eff[N-1];
        end else if (r_state == RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_a     <= r_a >> W;
            r_b     <= r_b >> W;
            r_carry <= w_sum[W];
            r_y     <= w_y_next;
            if (w_last) begin
                r_c <= w_sum[W];
                r_z <= (w_y_next == '0);
                r_v <= (r_a_msb == r_b_msb) && (w_y_next[N-1] != r_a_msb);
                r_n <= w_y_next[N-1];
            end
        end
    end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits.
REQ-002 SHALL have parameter W, default 4, meaning digit width processed per cycle; N % W == 0 and 1 <= W <= N are required, checked by an elaboration-time assertion.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, in this port order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
- a, b  input  N  operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  N  result
- c_flag, z_flag, v_flag, n_flag  output  1 each  carry, zero, overflow, negative

Function
REQ-004 SHALL implement states IDLE, RUN and DONE; K = N/W.
REQ-005 in_ready SHALL equal (state == IDLE).
REQ-006 On an edge with in_valid && in_ready: a, b and op SHALL be latched, the digit counter cleared, the carry-in loaded, and the state set to RUN.
REQ-007 Carry-in SHALL be 0 for ADD, 1 for SUB, the registered c_flag for ADC, and the registered c_flag for SBC.
REQ-008 Subtract ops SHALL compute a + ~b + cin, so for SUB and SBC c_flag=1 means no borrow.
REQ-009 Each RUN edge SHALL compute one W-bit digit, starting at the LSB digit, write it into y, and propagate the digit carry.
REQ-010 After the K-th RUN edge, the state SHALL be DONE and out_valid SHALL be 1.
- Acceptance at edge E0 gives out_valid high after edge EK.
- Latency is therefore K cycles.
REQ-011 On entering DONE, the flags SHALL update together:
- c_flag: carry out of the MSB digit.
- v_flag: (a[N-1] == b_eff[N-1]) && (y[N-1] != a[N-1]), where b_eff = b for add ops and ~b for subtract ops.
- z_flag: (y == 0).
- n_flag: y[N-1].
REQ-012 Flags SHALL hold their values from the previous completed op during IDLE and RUN.
REQ-013 While the state is RUN, y SHALL be treated as undefined.
REQ-014 In DONE, y and the flags SHALL hold stable until out_valid && out_ready.
REQ-015 DONE SHALL go to IDLE on the same edge that out_ready is seen high.
REQ-016 y and the flags SHALL then hold their values in IDLE.
REQ-017 out_ready low in DONE SHALL hold the state indefinitely, with no new acceptance.
REQ-018 in_valid SHALL be ignored in RUN and DONE.
REQ-019 Operands changing after acceptance SHALL have no effect on the result.
REQ-020 With W == N, the result SHALL complete in one RUN cycle (K=1).
REQ-021 The digit counter SHALL be clog2(K)+1 bits wide and SHALL NOT wrap during RUN.

Reset
REQ-022 Assertion of rst SHALL immediately, asynchronously, set: state IDLE, y=0, c_flag=0, z_flag=0, v_flag=0, n_flag=0, out_valid=0 (hence in_ready=1).
REQ-023 rst asserted mid-RUN or in DONE SHALL abort the operation; no out_valid SHALL follow it.
REQ-024 After rst deasserts, the first ADC or SBC SHALL use carry-in 0.

Verification (N=8, W=4, K=2)
REQ-025 Accept SUB a=0x80 b=0x01 -> out_valid exactly 2 edges later with y=0x7F, c=1, v=1, z=0, n=0.
REQ-026 SUB a=0x00 b=0x01 -> y=0xFF, c=0, v=0, n=1. Then SBC a=0x00 b=0x00 -> y=0xFF, c=0, n=1 (borrow chained via cin=c_flag=0).
REQ-027 ADD a=0xFF b=0x01 -> y=0x00, c=1, z=1, v=0. Then ADC a=0x01 b=0x01 -> y=0x03, c=0.
REQ-028 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, y and flags stable. out_ready=1 -> IDLE the next edge, then the new op is accepted.
REQ-029 Assert rst one edge after accepting ADD 0x10+0x20 -> y=0, all flags 0, in_ready=1, and no out_valid. Then ADC 0x01+0x01 -> 0x02.
REQ-030 Rerun REQ-025..REQ-027 with W=8 and W=2 -> identical results, with latency 1 and 4 respectively.
